// File: rtl/medfilt_pkg.sv
// Shared types and constants for the median-filter datapath:
// pixel/word geometry and the window feeder state encoding.
package medfilt_pkg;

  localparam int PIX_W        = 16;
  localparam int PIX_PER_WORD = 4;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    CAP,
    OFFER,
    TAKE,
    DONE
  } feed_state_t;

  // Read data lags its address by one cycle, so row slot idx is captured
  // on the edge that closes the state after the one that issued its address.
  function automatic feed_state_t capture_state(input int idx);
    feed_state_t s;
    s = CAP;
    if (idx == 0) s = RD1;
    else if (idx == 1) s = RD2;
    return s;
  endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// Scan-position counters (row base r, column word c) for the window feeder,
// plus the three row-offset read addresses for the current position.
module feeder_addr_gen
  import medfilt_pkg::*;
#(
  parameter int IMG_WORDS = 4,
  parameter int IMG_ROWS  = 8,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic              last,
  output logic [ADDR_W-1:0] addr_row0,
  output logic [ADDR_W-1:0] addr_row1,
  output logic [ADDR_W-1:0] addr_row2,
  output logic [ADDR_W-1:0] addr_step
);

  localparam int CW     = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
  localparam int RW     = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
  localparam int LAST_R = (IMG_ROWS >= 3) ? IMG_ROWS - 3 : 0;
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_WORDS);

  logic [CW-1:0] c_reg;
  logic [RW-1:0] r_reg;
  logic          c_wrap;

  assign c_wrap = (int'(c_reg) == IMG_WORDS - 1);
  assign last   = c_wrap && (int'(r_reg) == LAST_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg <= '0;
      r_reg <= '0;
    end else if (clr) begin
      c_reg <= '0;
      r_reg <= '0;
    end else if (adv) begin
      if (c_wrap) begin
        c_reg <= '0;
        r_reg <= r_reg + RW'(1);
      end else begin
        c_reg <= c_reg + CW'(1);
      end
    end
  end

  // Lower rows are derived from the base address rather than from r+1/r+2,
  // so the row counter never has to represent rows beyond the last base.
  assign addr_row0 = ADDR_W'(r_reg) * ROW_STRIDE + ADDR_W'(c_reg);
  assign addr_row1 = addr_row0 + ROW_STRIDE;
  assign addr_row2 = addr_row1 + ROW_STRIDE;

  // Row-major layout: the next scan position is always one word further on,
  // including across the column wrap ((r,W-1) -> (r+1,0)).
  assign addr_step = addr_row0 + ADDR_W'(1);

endmodule

// File: rtl/window_feeder.sv
// Fetches three vertically adjacent 64-bit row words per column position and
// offers them to the 3x3 window generator under its ready-level handshake.
module window_feeder
  import medfilt_pkg::*;
#(
  parameter int IMG_WORDS = 4,
  parameter int IMG_ROWS  = 8,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              data_get_flag,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] data1,
  output logic [WORD_W-1:0] data2,
  output logic [WORD_W-1:0] data3,
  output logic              nxt_data_flag,
  output logic              busy,
  output logic              done
);

  localparam bit SHORT_IMG = (IMG_ROWS < 3);

  feed_state_t state_reg, state_next;

  logic              pos_clr, pos_adv, pos_last;
  logic [ADDR_W-1:0] addr_row0, addr_row1, addr_row2, addr_step;

  logic              mem_rd_en_reg, mem_rd_en_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic              nxt_flag_reg, nxt_flag_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  feeder_addr_gen #(
    .IMG_WORDS (IMG_WORDS),
    .IMG_ROWS  (IMG_ROWS),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pos_clr),
    .adv       (pos_adv),
    .last      (pos_last),
    .addr_row0 (addr_row0),
    .addr_row1 (addr_row1),
    .addr_row2 (addr_row2),
    .addr_step (addr_step)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mem_rd_en_reg <= 1'b0;
      mem_addr_reg  <= '0;
      nxt_flag_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_rd_en_reg <= mem_rd_en_next;
      mem_addr_reg  <= mem_addr_next;
      nxt_flag_reg  <= nxt_flag_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHORT_IMG ? DONE : RD0;
      RD0:     state_next = RD1;
      RD1:     state_next = RD2;
      RD2:     state_next = CAP;
      CAP:     state_next = OFFER;
      OFFER:   if (data_get_flag) state_next = TAKE;
      TAKE:    if (!data_get_flag) state_next = pos_last ? DONE : RD0;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    mem_rd_en_next = 1'b0;
    mem_addr_next  = '0;
    nxt_flag_next  = (state_reg == OFFER) && data_get_flag;
    busy_next      = (state_next != IDLE);
    done_next      = (state_next == DONE);
    pos_clr        = (state_reg == DONE);
    pos_adv        = (state_reg == TAKE) && !data_get_flag && !pos_last;
    case (state_next)
      RD0: begin
        mem_rd_en_next = 1'b1;
        // Counters advance on this same edge, so use the stepped address.
        mem_addr_next  = (state_reg == TAKE) ? addr_step : addr_row0;
      end
      RD1: begin
        mem_rd_en_next = 1'b1;
        mem_addr_next  = addr_row1;
      end
      RD2: begin
        mem_rd_en_next = 1'b1;
        mem_addr_next  = addr_row2;
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [WORD_W-1:0] row_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_reg <= '0;
        end else if (state_reg == capture_state(gi)) begin
          row_reg <= mem_rdata;
        end
      end
    end
  endgenerate

  assign data1         = g_row[0].row_reg;
  assign data2         = g_row[1].row_reg;
  assign data3         = g_row[2].row_reg;
  assign mem_rd_en     = mem_rd_en_reg;
  assign mem_addr      = mem_addr_reg;
  assign nxt_data_flag = nxt_flag_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_window_feeder.sv
// Bench for window_feeder: scan-order model of addresses and offered row
// triples, a randomisable consumer, and targeted timing/reset scenarios.
module tb_window_feeder;

  localparam int W      = 4;
  localparam int R      = 4;
  localparam int AW     = 8;
  localparam int NPOS   = W * (R - 2);
  localparam int NREADS = 3 * NPOS;

  logic        clk = 1'b0;
  logic        rst_n, start, start2, data_get_flag;
  logic        mem_rd_en, nxt_data_flag, busy, done;
  logic [AW-1:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  logic [63:0] data1, data2, data3;

  logic        mem_rd_en2, nxt2, busy2, done2;
  logic [AW-1:0] mem_addr2;
  logic [63:0] d1_2, d2_2, d3_2;
  logic [63:0] zero_word = '0;

  int tests_run = 0, tests_failed = 0;
  int rd_idx = 0, off_idx = 0, done_cnt = 0, offers_at_done = 0, pulse_cnt = 0;
  int mode = 0, stall_at = 0;
  logic hold_val = 1'b0, prev_nxt = 1'b0, prev_flag = 1'b0, small_bad = 1'b0;
  logic [63:0] first_d1, first_d2, first_d3, last_d1, last_d2, last_d3;

  always #5 clk = ~clk;

  window_feeder #(.IMG_WORDS(W), .IMG_ROWS(R), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_get_flag(data_get_flag),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .data1(data1), .data2(data2), .data3(data3),
    .nxt_data_flag(nxt_data_flag), .busy(busy), .done(done)
  );

  window_feeder #(.IMG_WORDS(W), .IMG_ROWS(2), .ADDR_W(AW)) dut_short (
    .clk(clk), .rst_n(rst_n), .start(start2), .data_get_flag(1'b1),
    .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .mem_rdata(zero_word),
    .data1(d1_2), .data2(d2_2), .data3(d3_2),
    .nxt_data_flag(nxt2), .busy(busy2), .done(done2)
  );

  function automatic logic [63:0] mword(input int a);
    return {16'(4 * a + 3), 16'(4 * a + 2), 16'(4 * a + 1), 16'(4 * a)};
  endfunction

  // k-th read of a scan: position k/3 in row-major scan order, row slot k%3
  function automatic int exp_addr(input int k);
    int pos = k / 3;
    return (pos / W + k % 3) * W + pos % W;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mword(int'(mem_addr));
  end

  // Scoreboard: every read address and every offer against the scan model
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_idx = 0; off_idx = 0; prev_nxt = 1'b0; prev_flag = 1'b0;
    end else begin
      if (mem_rd_en2 || nxt2 || mem_addr2 != '0 || d1_2 != '0 || d2_2 != '0 || d3_2 != '0)
        small_bad = 1'b1;
      if (mem_rd_en) begin
        if (rd_idx < NREADS) check($sformatf("rd_addr[%0d]", rd_idx), 64'(mem_addr), 64'(exp_addr(rd_idx)));
        else check("rd_overrun", 64'(rd_idx), 64'(NREADS - 1));
        rd_idx++;
      end
      if (nxt_data_flag) begin
        check("offer_prev_flag", 64'(prev_flag), 64'd1);
        check("offer_back2back", 64'(prev_nxt), 64'd0);
        if (off_idx < NPOS) begin
          check($sformatf("offer%0d_d1", off_idx), data1, mword((off_idx / W) * W + off_idx % W));
          check($sformatf("offer%0d_d2", off_idx), data2, mword((off_idx / W + 1) * W + off_idx % W));
          check($sformatf("offer%0d_d3", off_idx), data3, mword((off_idx / W + 2) * W + off_idx % W));
        end else begin
          check("offer_overrun", 64'(off_idx), 64'(NPOS - 1));
        end
        if (off_idx == 0) begin first_d1 = data1; first_d2 = data2; first_d3 = data3; end
        if (off_idx == NPOS - 1) begin last_d1 = data1; last_d2 = data2; last_d3 = data3; end
        off_idx++;
      end
      if (done) begin
        check("done_offers", 64'(off_idx), 64'(NPOS));
        check("done_reads", 64'(rd_idx), 64'(NREADS));
        offers_at_done = off_idx;
        done_cnt++;
        rd_idx = 0; off_idx = 0;
      end
      prev_nxt = nxt_data_flag;
      prev_flag = data_get_flag;
    end
  end

  // Consumer: 0 = registered ready (drops the cycle after a pulse, optionally
  // staying high after pulse #stall_at), 1 = random ready, 2 = held at hold_val
  initial begin : consumer
    logic p;
    data_get_flag = 1'b0;
    forever begin
      @(negedge clk);
      p = nxt_data_flag;
      if (!rst_n || done) pulse_cnt = 0;
      else if (p) pulse_cnt++;
      @(posedge clk); #1;
      case (mode)
        0:       data_get_flag = !(p && pulse_cnt != stall_at);
        1:       data_get_flag = p ? 1'b0 : ($urandom_range(0, 2) != 0);
        default: data_get_flag = hold_val;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name, input int lim);
    int n = 0;
    while (n < lim) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= lim) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic kick();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [63:0] h1, h2, h3;
    int dc, n;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_data", data1 | data2 | data3, 64'd0);
    check("rst_ctrl", {61'd0, nxt_data_flag, busy, done}, 64'd0);
    tick(); rst_n = 1'b1;

    // Scan A: fetch timing and scan-order literals
    kick();
    @(negedge clk);
    check("A_c1_rd_en", 64'(mem_rd_en), 64'd1);
    check("A_c1_addr", 64'(mem_addr), 64'd0);
    check("A_c1_busy", 64'(busy), 64'd1);
    @(negedge clk); check("A_c2_addr", 64'(mem_addr), 64'd4);
    @(negedge clk); check("A_c3_addr", 64'(mem_addr), 64'd8);
    @(negedge clk); check("A_c4_rd_en", 64'(mem_rd_en), 64'd0);
    @(negedge clk); check("A_c5_nxt", 64'(nxt_data_flag), 64'd0);
    @(negedge clk); check("A_c6_nxt", 64'(nxt_data_flag), 64'd1);
    wait_done("A", 400);
    @(negedge clk);
    check("A_busy_after_done", 64'(busy), 64'd0);
    check("A_offers", 64'(offers_at_done), 64'd8);
    check("A_first_d1", first_d1, 64'h0003_0002_0001_0000);
    check("A_first_d2", first_d2, 64'h0013_0012_0011_0010);
    check("A_first_d3", first_d3, 64'h0023_0022_0021_0020);
    check("A_last_d1", last_d1, 64'h001f_001e_001d_001c);
    check("A_last_d2", last_d2, 64'h002f_002e_002d_002c);
    check("A_last_d3", last_d3, 64'h003f_003e_003d_003c);

    // Scan B: random consumer, start held high through one scan into the next
    mode = 1;
    dc = done_cnt;
    tick(); start = 1'b1;
    wait_done("B1", 2000);
    @(negedge clk); check("B_idle_gap_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("B_restart_rd_en", 64'(mem_rd_en), 64'd1);
    check("B_restart_addr", 64'(mem_addr), 64'd0);
    for (int i = 0; i < 30; i++) begin
      tick(); start = 1'($urandom_range(0, 1));
    end
    tick(); start = 1'b0;
    wait_done("B2", 2000);
    @(negedge clk);
    check("B_done_count", 64'(done_cnt - dc), 64'd2);

    // Scan C: consumer not ready for 20 cycles in OFFER
    mode = 2; hold_val = 1'b0;
    kick();
    repeat (4) tick();
    @(negedge clk);
    h1 = data1; h2 = data2; h3 = data3;
    check("C_hold_d1", h1, 64'h0003_0002_0001_0000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("C_hold_nxt[%0d]", i), 64'(nxt_data_flag), 64'd0);
      check($sformatf("C_hold_data[%0d]", i), 64'((data1 != h1) || (data2 != h2) || (data3 != h3)), 64'd0);
    end
    hold_val = 1'b1;
    @(negedge clk); check("C_rise_nxt", 64'(nxt_data_flag), 64'd0);
    @(negedge clk); check("C_pulse_nxt", 64'(nxt_data_flag), 64'd1);
    mode = 0;
    wait_done("C", 400);
    @(negedge clk);

    // Scan D: reset while stalled in TAKE of the fifth word
    stall_at = 5;
    dc = done_cnt;
    kick();
    n = 0;
    while (pulse_cnt < 5 && n < 400) begin @(negedge clk); n++; end
    check("D_reach_word5", 64'(n < 400), 64'd1);
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("D_rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("D_rst_addr", 64'(mem_addr), 64'd0);
    check("D_rst_data", data1 | data2 | data3, 64'd0);
    check("D_rst_ctrl", {61'd0, nxt_data_flag, busy, done}, 64'd0);
    stall_at = 0;
    tick(); tick(); rst_n = 1'b1;
    kick();
    @(negedge clk); check("D_re_addr0", 64'(mem_addr), 64'd0);
    @(negedge clk); check("D_re_addr1", 64'(mem_addr), 64'd4);
    @(negedge clk); check("D_re_addr2", 64'(mem_addr), 64'd8);
    wait_done("D", 400);
    @(negedge clk);
    check("D_done_count", 64'(done_cnt - dc), 64'd1);

    // Short image: straight to DONE, no reads, no offers
    tick(); start2 = 1'b1;
    tick(); start2 = 1'b0;
    @(negedge clk);
    check("S_done", 64'(done2), 64'd1);
    check("S_busy", 64'(busy2), 64'd1);
    @(negedge clk);
    check("S_done_end", 64'({done2, busy2}), 64'd0);
    repeat (3) @(negedge clk);
    check("S_no_activity", 64'(small_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
